// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, runs the instruction SRAM req/resp handshake, feeds IF/ID.
// Optional address-error detection on misaligned PCs is enabled with `define IF_FETCH_ADEL_EN.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'hBFC0_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        BranchD,
    input  logic        Jump,
    input  logic        JumpReg,
    input  logic        EPC_sel,
    input  logic [31:0] Branch_addr,
    input  logic [31:0] Jump_addr,
    input  logic [31:0] PCSrc_reg,
    input  logic [31:0] EPC,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic [31:0] inst_rdata,
    output logic [31:0] instr,
    output logic [31:0] pc_plus_4,
    output logic [31:0] PCin,
    output logic        instr_valid
`ifdef IF_FETCH_ADEL_EN
    ,
    output logic        fetch_adel,
    output logic [31:0] fetch_badvaddr
`endif
);

    localparam int unsigned XLEN = 32;

    localparam logic [1:0] S_REQ    = 2'd0;
    localparam logic [1:0] S_WAIT   = 2'd1;
    localparam logic [1:0] S_HOLD   = 2'd2;
    localparam logic [1:0] S_CANCEL = 2'd3;

    logic [1:0]      state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;
    logic [XLEN-1:0] hold_q, hold_d;
    logic            cancel_q, cancel_d;
    logic            inst_req_q, inst_req_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic [XLEN-1:0] pcin_q, pcin_d;
    logic [XLEN-1:0] pc_plus_4_q, pc_plus_4_d;
    logic            valid_q, valid_d;

    logic            redirect;
    logic [XLEN-1:0] target;
    logic            data_ok;
    logic            accepted;
    logic            deliver;
    logic [XLEN-1:0] deliver_word;

`ifdef IF_FETCH_ADEL_EN
    logic            adel_done_q, adel_done_d;
    logic            adel_q, adel_d;
    logic [XLEN-1:0] badvaddr_q, badvaddr_d;
    logic            adel_deliver;
`endif

    assign redirect = !stall && (EPC_sel || JumpReg || Jump || BranchD);
    // Responses are ignored after reset until the first new request is accepted.
    assign data_ok  = inst_data_ok && !cancel_q;
    assign accepted = (state_q == S_REQ) && inst_req_q && inst_addr_ok;

    always_comb begin
        if (EPC_sel)      target = EPC;
        else if (JumpReg) target = PCSrc_reg;
        else if (Jump)    target = Jump_addr;
        else              target = Branch_addr;
    end

    // Next-state, PC and IF/ID output logic.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        redirect_pc_d = redirect_pc_q;
        hold_d        = hold_q;
        cancel_d      = cancel_q && !accepted;
        deliver       = 1'b0;
        deliver_word  = inst_rdata;
        instr_d       = instr_q;
        pcin_d        = pcin_q;
        pc_plus_4_d   = pc_plus_4_q;
        valid_d       = valid_q;
`ifdef IF_FETCH_ADEL_EN
        adel_done_d   = adel_done_q;
        adel_d        = adel_q;
        badvaddr_d    = badvaddr_q;
        adel_deliver  = 1'b0;
`endif
        case (state_q)
            S_REQ: begin
                if (accepted) begin
                    // Request for the old PC already went out; its response must be dropped.
                    if (redirect) begin
                        redirect_pc_d = target;
                        state_d       = S_CANCEL;
                    end else begin
                        state_d = S_WAIT;
                    end
                end else if (redirect) begin
                    pc_d = target;
`ifdef IF_FETCH_ADEL_EN
                    adel_done_d = 1'b0;
`endif
                end
`ifdef IF_FETCH_ADEL_EN
                else if ((pc_q[1:0] != 2'b00) && !adel_done_q && !stall) begin
                    deliver      = 1'b1;
                    deliver_word = NOP_INSTR;
                    adel_deliver = 1'b1;
                    adel_done_d  = 1'b1;
                end
`endif
            end
            S_WAIT: begin
                if (data_ok) begin
                    if (redirect) begin
                        pc_d    = target;
                        state_d = S_REQ;
                    end else if (!stall) begin
                        deliver = 1'b1;
                        pc_d    = pc_q + 32'd4;
                        state_d = S_REQ;
                    end else begin
                        hold_d  = inst_rdata;
                        state_d = S_HOLD;
                    end
                end else if (redirect) begin
                    redirect_pc_d = target;
                    state_d       = S_CANCEL;
                end
            end
            S_HOLD: begin
                if (!stall) begin
                    state_d = S_REQ;
                    if (redirect) begin
                        pc_d = target;
                    end else begin
                        deliver      = 1'b1;
                        deliver_word = hold_q;
                        pc_d         = pc_q + 32'd4;
                    end
                end
            end
            S_CANCEL: begin
                if (redirect) redirect_pc_d = target;
                if (data_ok) begin
                    pc_d    = redirect ? target : redirect_pc_q;
                    state_d = S_REQ;
                end
            end
            default: state_d = S_REQ;
        endcase

        inst_req_d = (state_d == S_REQ);
`ifdef IF_FETCH_ADEL_EN
        inst_req_d = (state_d == S_REQ) && (pc_d[1:0] == 2'b00);
`endif

        // Outputs freeze under stall; otherwise a delivery shows for exactly one cycle.
        if (!stall) begin
            instr_d = deliver ? deliver_word : NOP_INSTR;
            valid_d = deliver;
            if (deliver) begin
                pcin_d      = pc_q;
                pc_plus_4_d = pc_q + 32'd4;
            end
`ifdef IF_FETCH_ADEL_EN
            adel_d = adel_deliver;
            if (adel_deliver) badvaddr_d = pc_q;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_REQ;
            pc_q          <= RESET_PC;
            redirect_pc_q <= '0;
            hold_q        <= '0;
            cancel_q      <= 1'b1;
            inst_req_q    <= 1'b0;
            instr_q       <= NOP_INSTR;
            pcin_q        <= RESET_PC;
            pc_plus_4_q   <= RESET_PC + 32'd4;
            valid_q       <= 1'b0;
`ifdef IF_FETCH_ADEL_EN
            adel_done_q   <= 1'b0;
            adel_q        <= 1'b0;
            badvaddr_q    <= '0;
`endif
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            redirect_pc_q <= redirect_pc_d;
            hold_q        <= hold_d;
            cancel_q      <= cancel_d;
            inst_req_q    <= inst_req_d;
            instr_q       <= instr_d;
            pcin_q        <= pcin_d;
            pc_plus_4_q   <= pc_plus_4_d;
            valid_q       <= valid_d;
`ifdef IF_FETCH_ADEL_EN
            adel_done_q   <= adel_done_d;
            adel_q        <= adel_d;
            badvaddr_q    <= badvaddr_d;
`endif
        end
    end

    assign inst_req    = inst_req_q;
    assign inst_addr   = {pc_q[XLEN-1:2], 2'b00};
    assign instr       = instr_q;
    assign PCin        = pcin_q;
    assign pc_plus_4   = pc_plus_4_q;
    assign instr_valid = valid_q;
`ifdef IF_FETCH_ADEL_EN
    assign fetch_adel     = adel_q;
    assign fetch_badvaddr = badvaddr_q;
`endif

endmodule
